// File: rtl/key_conditioner.sv
// Push-button conditioner: sync, debounce, one-shot press pulse and long-hold
// pulse for KEY0 (start) and KEY1 (pause), two identical channels.
module key_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned HOLD_CYCLES     = 100_000_000,
   parameter int unsigned CNT_W           = 27
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       key0_raw,
   input  logic       key1_raw,
   output logic       start,
   output logic       pause,
   output logic [1:0] key_level,
   output logic [1:0] hold_pulse
);

   typedef enum logic [1:0] {
      RELEASED = 2'd0,
      PRESSED  = 2'd1,
      HELD     = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   logic [1:0]       raw;
   logic [1:0]       s1_q, s2_q;
   logic [1:0]       lvl_q, lvl_d;
   logic [1:0]       press_q, press_d;
   logic [1:0]       hold_q, hold_d;
   logic [CNT_W-1:0] dcnt_q [2];
   logic [CNT_W-1:0] dcnt_d [2];
   logic [CNT_W-1:0] hcnt_q [2];
   logic [CNT_W-1:0] hcnt_d [2];
   state_e           state_q [2];
   state_e           state_d [2];

   assign raw = {key1_raw, key0_raw};

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_q    <= 2'b11;
         s2_q    <= 2'b11;
         lvl_q   <= 2'b11;
         press_q <= 2'b11;
         hold_q  <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            dcnt_q[i]  <= '0;
            hcnt_q[i]  <= '0;
            state_q[i] <= RELEASED;
         end
      end else begin
         s1_q    <= raw;
         s2_q    <= s1_q;
         lvl_q   <= lvl_d;
         press_q <= press_d;
         hold_q  <= hold_d;
         for (int i = 0; i < 2; i++) begin
            dcnt_q[i]  <= dcnt_d[i];
            hcnt_q[i]  <= hcnt_d[i];
            state_q[i] <= state_d[i];
         end
      end
   end

   // The press pulse is registered on the same edge that accepts the new level.
   always_comb begin
      lvl_d   = lvl_q;
      press_d = 2'b11;
      hold_d  = 2'b00;
      for (int i = 0; i < 2; i++) begin
         dcnt_d[i]  = dcnt_q[i];
         hcnt_d[i]  = hcnt_q[i];
         state_d[i] = state_q[i];
      end
      for (int i = 0; i < 2; i++) begin
         if (s2_q[i] == lvl_q[i]) begin
            dcnt_d[i] = '0;
         end else if (dcnt_q[i] == DB_LAST) begin
            lvl_d[i]  = s2_q[i];
            dcnt_d[i] = '0;
         end else begin
            dcnt_d[i] = dcnt_q[i] + ONE;
         end
         unique case (state_q[i])
            RELEASED: begin
               if (lvl_q[i] && !lvl_d[i]) begin
                  state_d[i] = PRESSED;
                  press_d[i] = 1'b0;
                  hcnt_d[i]  = '0;
               end
            end
            PRESSED: begin
               if (lvl_d[i]) begin
                  state_d[i] = RELEASED;
                  hcnt_d[i]  = '0;
               end else if (hcnt_q[i] == HOLD_LAST) begin
                  state_d[i] = HELD;
                  hold_d[i]  = 1'b1;
               end else begin
                  hcnt_d[i] = hcnt_q[i] + ONE;
               end
            end
            HELD: begin
               if (lvl_d[i]) begin
                  state_d[i] = RELEASED;
                  hcnt_d[i]  = '0;
               end
            end
            default: begin
               state_d[i] = RELEASED;
               hcnt_d[i]  = '0;
            end
         endcase
      end
   end

   assign start      = press_q[0];
   assign pause      = press_q[1];
   assign key_level  = lvl_q;
   assign hold_pulse = hold_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
module tb_key_conditioner;

   logic       clock;
   logic       reset;
   logic       key0_raw;
   logic       key1_raw;
   logic       start;
   logic       pause;
   logic [1:0] key_level;
   logic [1:0] hold_pulse;

   int checks = 0;
   int errors = 0;

   key_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .HOLD_CYCLES    (10),
      .CNT_W          (8)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .key0_raw  (key0_raw),
      .key1_raw  (key1_raw),
      .start     (start),
      .pause     (pause),
      .key_level (key_level),
      .hold_pulse(hold_pulse)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [1:0] obs,
                      input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Run n edges; cycle c=1 is the first edge sampling the current inputs.
   // p0/p1: cycle of start/pause low pulse; h0/h1: cycle of hold pulse;
   // key_level[i] expected low for la<=c<lb. -1 / 0,0 mean never.
   task automatic watch(input string ph, input int n,
                        input int p0, input int p1,
                        input int h0, input int h1,
                        input int l0a, input int l0b,
                        input int l1a, input int l1b);
      logic [1:0] e;
      for (int c = 1; c <= n; c++) begin
         @(posedge clock);
         #1;
         e = {1'b0, (c == p0) ? 1'b0 : 1'b1};
         chk($sformatf("%s c%0d start", ph, c), {1'b0, start}, e);
         e = {1'b0, (c == p1) ? 1'b0 : 1'b1};
         chk($sformatf("%s c%0d pause", ph, c), {1'b0, pause}, e);
         e = {(c == h1), (c == h0)};
         chk($sformatf("%s c%0d hold", ph, c), hold_pulse, e);
         e = {!(c >= l1a && c < l1b), !(c >= l0a && c < l0b)};
         chk($sformatf("%s c%0d level", ph, c), key_level, e);
      end
   endtask

   initial begin
      reset    = 1'b1;
      key0_raw = 1'b0;
      key1_raw = 1'b0;

      // reset with both keys held low
      watch("rst", 3, -1, -1, -1, -1, 0, 0, 0, 0);
      reset = 1'b0;
      watch("rst_rel", 8, 6, 6, -1, -1, 6, 1000, 6, 1000);
      key0_raw = 1'b1;
      key1_raw = 1'b1;
      watch("rst_up", 8, -1, -1, -1, -1, 1, 6, 1, 6);

      // clean press and long hold on KEY0
      key0_raw = 1'b0;
      watch("hold1", 30, 6, -1, 16, -1, 6, 1000, 0, 0);
      key0_raw = 1'b1;
      watch("hold1_up", 8, -1, -1, -1, -1, 1, 6, 0, 0);
      key0_raw = 1'b0;
      watch("hold2", 20, 6, -1, 16, -1, 6, 1000, 0, 0);
      key0_raw = 1'b1;
      watch("hold2_up", 8, -1, -1, -1, -1, 1, 6, 0, 0);

      // bounce on KEY1 must be rejected
      key1_raw = 1'b0;
      watch("bnc_a", 3, -1, -1, -1, -1, 0, 0, 0, 0);
      key1_raw = 1'b1;
      watch("bnc_b", 1, -1, -1, -1, -1, 0, 0, 0, 0);
      key1_raw = 1'b0;
      watch("bnc_c", 2, -1, -1, -1, -1, 0, 0, 0, 0);
      key1_raw = 1'b1;
      watch("bnc_d", 5, -1, -1, -1, -1, 0, 0, 0, 0);
      key1_raw = 1'b0;
      watch("bnc_ok", 8, -1, 6, -1, -1, 0, 0, 6, 1000);
      key1_raw = 1'b1;
      watch("bnc_up", 8, -1, -1, -1, -1, 0, 0, 1, 6);

      // simultaneous press, held into both hold pulses
      key0_raw = 1'b0;
      key1_raw = 1'b0;
      watch("both", 20, 6, 6, 16, 16, 6, 1000, 6, 1000);
      key0_raw = 1'b1;
      key1_raw = 1'b1;
      watch("both_up", 8, -1, -1, -1, -1, 1, 6, 1, 6);

      // reset in the middle of a KEY1 debounce
      key1_raw = 1'b0;
      watch("mid_a", 3, -1, -1, -1, -1, 0, 0, 0, 0);
      reset = 1'b1;
      watch("mid_rst", 1, -1, -1, -1, -1, 0, 0, 0, 0);
      reset = 1'b0;
      watch("mid_b", 8, -1, 6, -1, -1, 0, 0, 6, 1000);
      key1_raw = 1'b1;
      watch("mid_up", 8, -1, -1, -1, -1, 0, 0, 1, 6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
